// File: rtl/ddr3_dfi_sched_pkg.sv
// rtl/ddr3_dfi_sched_pkg.sv - DDR3 command encodings and DFI constants for the scheduler
package ddr3_dfi_sched_pkg;

   localparam int DDR_BANK_BITS = 3;

   // {cs_n, ras_n, cas_n, we_n}
   typedef enum logic [3:0] {
      CMD_MRS  = 4'b0000,
      CMD_REF  = 4'b0001,
      CMD_PRE  = 4'b0010,
      CMD_ACT  = 4'b0011,
      CMD_WR   = 4'b0100,
      CMD_RD   = 4'b0101,
      CMD_ZQCL = 4'b0110,
      CMD_NOP  = 4'b0111
   } ddr_cmd_e;

   localparam logic [3:0] DFI_NOP      = 4'b0111;
   localparam logic [3:0] DFI_DESELECT = 4'b1111;

   function automatic int cnt_width(input int max_load);
      return (max_load < 1) ? 1 : $clog2(max_load + 1);
   endfunction

endpackage

// File: rtl/ddr3_dfi_sched_if.sv
// rtl/ddr3_dfi_sched_if.sv - controller-side command, write-data and read-data bundle
interface ddr3_dfi_sched_if
   import ddr3_dfi_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_BITS   = 15
);
   logic                     enable_i;
   logic [3:0]               command_i;
   logic                     accept_o;
   logic [DDR_BANK_BITS-1:0] bank_i;
   logic [ROW_BITS-1:0]      addr_i;
   logic                     wvalid_i;
   logic                     wready_o;
   logic                     wrlast_i;
   logic [DATA_WIDTH/8-1:0]  wrmask_i;
   logic [DATA_WIDTH-1:0]    wrdata_i;
   logic                     rvalid_o;
   logic                     rready_i;
   logic                     rdlast_o;
   logic [DATA_WIDTH-1:0]    rddata_o;

   modport master (
      output enable_i, command_i, bank_i, addr_i, wvalid_i, wrlast_i, wrmask_i, wrdata_i, rready_i,
      input  accept_o, wready_o, rvalid_o, rdlast_o, rddata_o
   );

   modport slave (
      input  enable_i, command_i, bank_i, addr_i, wvalid_i, wrlast_i, wrmask_i, wrdata_i, rready_i,
      output accept_o, wready_o, rvalid_o, rdlast_o, rddata_o
   );
endinterface

// File: rtl/ddr3_dfi_window.sv
// rtl/ddr3_dfi_window.sv - delay-line strobe: high from DELAY-PRE to DELAY+LENGTH-1+POST cycles after trigger
module ddr3_dfi_window #(
   parameter int DELAY  = 2,
   parameter int LENGTH = 1,
   parameter int PRE    = 0,
   parameter int POST   = 0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic trigger,
   output logic strobe
);
   localparam int FIRST = DELAY - PRE;
   localparam int LAST  = DELAY + LENGTH - 1 + POST;
   localparam int DEPTH = LAST + 1;

   logic [DEPTH-1:0] line;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line <= '0;
      end else begin
         line <= {line[DEPTH-2:0], trigger};
      end
   end

   // Bit k is set in the k-th cycle after the command reaches the DFI bus.
   assign strobe = |line[LAST:FIRST];

endmodule

// File: rtl/ddr3_dfi_sched.sv
// rtl/ddr3_dfi_sched.sv - DDR3 DFI command register, CAS spacing and data strobe scheduler
module ddr3_dfi_sched
   import ddr3_dfi_sched_pkg::*;
#(
   parameter int DDR_WR_LATENCY = 6,
   parameter int DDR_RD_LATENCY = 5,
   parameter int BURST_CYCLES   = 2,
   parameter int TWTR_CYCLES    = 4,
   parameter int DDR_DATA_WIDTH = 32,
   parameter int DDR_DQM_WIDTH  = DDR_DATA_WIDTH / 8,
   parameter int DDR_ROW_BITS   = 15
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      cke_i,
   input  logic                      ddr_rst_n_i,
   ddr3_dfi_sched_if.slave           ctrl,
   output logic                      dfi_cke_o,
   output logic                      dfi_reset_n_o,
   output logic                      dfi_cs_n_o,
   output logic                      dfi_ras_n_o,
   output logic                      dfi_cas_n_o,
   output logic                      dfi_we_n_o,
   output logic                      dfi_odt_o,
   output logic [DDR_BANK_BITS-1:0]  dfi_bank_o,
   output logic [DDR_ROW_BITS-1:0]   dfi_addr_o,
   output logic                      dfi_wren_o,
   output logic [DDR_DQM_WIDTH-1:0]  dfi_mask_o,
   output logic [DDR_DATA_WIDTH-1:0] dfi_data_o,
   output logic                      dfi_rden_o,
   input  logic                      dfi_valid_i,
   input  logic [DDR_DATA_WIDTH-1:0] dfi_data_i,
   output logic                      wr_underrun_o,
   output logic                      rd_overflow_o,
   output logic                      wr_misalign_o
);
   localparam int CCD_LOAD = BURST_CYCLES - 1;
   localparam int WTR_LOAD = DDR_WR_LATENCY + BURST_CYCLES + TWTR_CYCLES - 1;
   localparam int RTW_RAW  = DDR_RD_LATENCY + BURST_CYCLES + 1 - DDR_WR_LATENCY;
   localparam int RTW_LOAD = (RTW_RAW > 1) ? RTW_RAW - 1 : 0;
   localparam int CCD_W    = cnt_width(CCD_LOAD);
   localparam int WTR_W    = cnt_width(WTR_LOAD);
   localparam int RTW_W    = cnt_width(RTW_LOAD);
   localparam int BEAT_W   = cnt_width(BURST_CYCLES - 1);

   logic [CCD_W-1:0]  ccd;
   logic [WTR_W-1:0]  wtr;
   logic [RTW_W-1:0]  rtw;
   logic [BEAT_W-1:0] beat;
   logic is_rd, is_wr, is_cas, accept, take, wr_take, rd_take, wren_last;

   assign is_rd   = (ctrl.command_i == CMD_RD);
   assign is_wr   = (ctrl.command_i == CMD_WR);
   assign is_cas  = is_rd | is_wr;
   assign accept  = !(is_cas && ccd != '0) && !(is_rd && wtr != '0) && !(is_wr && rtw != '0);
   assign take    = ctrl.enable_i & accept;
   assign wr_take = take & is_wr;
   assign rd_take = take & is_rd;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dfi_cke_o     <= 1'b0;
         dfi_reset_n_o <= 1'b0;
         {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= DFI_DESELECT;
         dfi_bank_o    <= '0;
         dfi_addr_o    <= '0;
      end else begin
         dfi_cke_o     <= cke_i;
         dfi_reset_n_o <= ddr_rst_n_i;
         if (take) begin
            {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= ctrl.command_i;
            dfi_bank_o <= ctrl.bank_i;
            dfi_addr_o <= ctrl.addr_i;
         end else begin
            {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} <= DFI_NOP;
         end
      end
   end

   // Spacing counters: reload on the accepted CAS, count down and hold at zero.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ccd <= '0;
         wtr <= '0;
         rtw <= '0;
      end else begin
         if (wr_take || rd_take) ccd <= CCD_W'(CCD_LOAD);
         else if (ccd != '0)     ccd <= ccd - CCD_W'(1);
         if (wr_take)            wtr <= WTR_W'(WTR_LOAD);
         else if (wtr != '0)     wtr <= wtr - WTR_W'(1);
         if (rd_take)            rtw <= RTW_W'(RTW_LOAD);
         else if (rtw != '0)     rtw <= rtw - RTW_W'(1);
      end
   end

   ddr3_dfi_window #(.DELAY(DDR_WR_LATENCY), .LENGTH(BURST_CYCLES), .PRE(0), .POST(0)) u_wren (
      .clock(clock), .reset_n(reset_n), .trigger(wr_take), .strobe(dfi_wren_o)
   );

   ddr3_dfi_window #(.DELAY(DDR_WR_LATENCY + BURST_CYCLES - 1), .LENGTH(1), .PRE(0), .POST(0)) u_wlast (
      .clock(clock), .reset_n(reset_n), .trigger(wr_take), .strobe(wren_last)
   );

   ddr3_dfi_window #(.DELAY(DDR_WR_LATENCY), .LENGTH(BURST_CYCLES), .PRE(1), .POST(1)) u_odt (
      .clock(clock), .reset_n(reset_n), .trigger(wr_take), .strobe(dfi_odt_o)
   );

   ddr3_dfi_window #(.DELAY(DDR_RD_LATENCY), .LENGTH(BURST_CYCLES), .PRE(0), .POST(0)) u_rden (
      .clock(clock), .reset_n(reset_n), .trigger(rd_take), .strobe(dfi_rden_o)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         beat          <= '0;
         wr_underrun_o <= 1'b0;
         wr_misalign_o <= 1'b0;
         rd_overflow_o <= 1'b0;
      end else begin
         if (dfi_valid_i)
            beat <= (beat == BEAT_W'(BURST_CYCLES - 1)) ? '0 : beat + BEAT_W'(1);
         if (dfi_wren_o && !ctrl.wvalid_i)     wr_underrun_o <= 1'b1;
         if (ctrl.wrlast_i != wren_last)       wr_misalign_o <= 1'b1;
         if (dfi_valid_i && !ctrl.rready_i)    rd_overflow_o <= 1'b1;
      end
   end

   assign ctrl.accept_o = accept;
   assign ctrl.wready_o = dfi_wren_o;
   assign dfi_data_o    = ctrl.wrdata_i;
   assign dfi_mask_o    = ctrl.wrmask_i;
   assign ctrl.rvalid_o = dfi_valid_i;
   assign ctrl.rddata_o = dfi_data_i;
   assign ctrl.rdlast_o = dfi_valid_i & (beat == BEAT_W'(BURST_CYCLES - 1));

   a_no_rw_overlap: assert property (@(posedge clock) disable iff (!reset_n) !(dfi_wren_o && dfi_rden_o));

endmodule

// File: tb/tb_ddr3_dfi_sched.sv
// tb/tb_ddr3_dfi_sched.sv - scoreboard bench for ddr3_dfi_sched
module tb_ddr3_dfi_sched;
   import ddr3_dfi_sched_pkg::*;

   localparam int WL = 6, RL = 5, BL = 2, TWTR = 4, DW = 32, MW = 4, RB = 15, N = 1024;

   logic clock = 1'b0, reset_n = 1'b0, cke_i = 1'b0, ddr_rst_n_i = 1'b0;
   logic dfi_cke_o, dfi_reset_n_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_odt_o;
   logic [2:0]    dfi_bank_o;
   logic [RB-1:0] dfi_addr_o;
   logic          dfi_wren_o, dfi_rden_o;
   logic [MW-1:0] dfi_mask_o;
   logic [DW-1:0] dfi_data_o;
   logic          dfi_valid_i = 1'b0;
   logic [DW-1:0] dfi_data_i = '0;
   logic          wr_underrun_o, rd_overflow_o, wr_misalign_o;

   ddr3_dfi_sched_if #(.DATA_WIDTH(DW), .ROW_BITS(RB)) bus();

   ddr3_dfi_sched #(
      .DDR_WR_LATENCY(WL), .DDR_RD_LATENCY(RL), .BURST_CYCLES(BL), .TWTR_CYCLES(TWTR),
      .DDR_DATA_WIDTH(DW), .DDR_ROW_BITS(RB)
   ) dut (
      .clock(clock), .reset_n(reset_n), .cke_i(cke_i), .ddr_rst_n_i(ddr_rst_n_i), .ctrl(bus),
      .dfi_cke_o(dfi_cke_o), .dfi_reset_n_o(dfi_reset_n_o), .dfi_cs_n_o(dfi_cs_n_o),
      .dfi_ras_n_o(dfi_ras_n_o), .dfi_cas_n_o(dfi_cas_n_o), .dfi_we_n_o(dfi_we_n_o),
      .dfi_odt_o(dfi_odt_o), .dfi_bank_o(dfi_bank_o), .dfi_addr_o(dfi_addr_o),
      .dfi_wren_o(dfi_wren_o), .dfi_mask_o(dfi_mask_o), .dfi_data_o(dfi_data_o),
      .dfi_rden_o(dfi_rden_o), .dfi_valid_i(dfi_valid_i), .dfi_data_i(dfi_data_i),
      .wr_underrun_o(wr_underrun_o), .rd_overflow_o(rd_overflow_o), .wr_misalign_o(wr_misalign_o)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   bit exp_wren [N];
   bit exp_odt  [N];
   bit exp_rden [N];
   bit exp_wlast[N];
   logic [DW-1:0] send_q[$];
   logic [DW-1:0] wexp_q[$];
   logic [DW:0]   rexp_q[$];
   bit mon_en = 1'b0;
   int drop_cyc = -1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [3:0] c, input logic [2:0] b, input logic [RB-1:0] a,
                        input logic [DW-1:0] d, input int maxw, output int acc, output int waits);
      bus.enable_i = 1'b1; bus.command_i = c; bus.bank_i = b; bus.addr_i = a;
      acc = -1; waits = 0;
      while (1) begin
         #1;
         if (bus.accept_o) begin acc = cyc; break; end
         if (waits >= maxw) break;
         waits++;
         step();
      end
      chk("accept_in_budget", acc >= 0, 1);
      if (acc >= 0) begin
         if (c == CMD_WR) begin
            for (int k = 0; k < BL; k++) begin
               exp_wren[acc + 1 + WL + k] = 1'b1;
               send_q.push_back(d ^ (32'h11111111 * k));
               wexp_q.push_back(d ^ (32'h11111111 * k));
            end
            exp_wlast[acc + WL + BL] = 1'b1;
            for (int k = WL - 1; k <= WL + BL; k++) exp_odt[acc + 1 + k] = 1'b1;
         end
         if (c == CMD_RD)
            for (int k = 0; k < BL; k++) exp_rden[acc + 1 + RL + k] = 1'b1;
         step();
      end
      bus.enable_i = 1'b0; bus.command_i = DFI_NOP;
      if (acc >= 0) begin
         #1;
         chk("dfi_cmd", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, c);
         chk("dfi_bank", dfi_bank_o, b);
         chk("dfi_addr", dfi_addr_o, a);
      end
   endtask

   // Write-data source: feeds the beats queued by each WR into the expected window.
   initial forever begin
      @(posedge clock);
      #1;
      if (cyc < N && exp_wren[cyc]) begin
         bus.wvalid_i = (cyc != drop_cyc);
         bus.wrlast_i = exp_wlast[cyc];
         bus.wrmask_i = 4'h0;
         bus.wrdata_i = (send_q.size() > 0) ? send_q.pop_front() : '0;
      end else begin
         bus.wvalid_i = 1'b0;
         bus.wrlast_i = 1'b0;
         bus.wrdata_i = '0;
      end
   end

   initial forever begin
      @(negedge clock);
      if (mon_en && cyc < N) begin
         chk("wren", dfi_wren_o, exp_wren[cyc]);
         chk("odt", dfi_odt_o, exp_odt[cyc]);
         chk("rden", dfi_rden_o, exp_rden[cyc]);
         if (dfi_wren_o) begin
            chk("wready", bus.wready_o, 1);
            chk("wdata_q_nonempty", wexp_q.size() > 0, 1);
            if (wexp_q.size() > 0) chk("wdata", dfi_data_o, wexp_q.pop_front());
         end
         if (bus.rvalid_o) begin
            chk("rdata_q_nonempty", rexp_q.size() > 0, 1);
            if (rexp_q.size() > 0) chk("rdata_last", {bus.rdlast_o, bus.rddata_o}, rexp_q.pop_front());
         end
      end
   end

   initial begin
      int a1, a2, a3, w;
      logic [DW-1:0] rd;
      bus.enable_i = 1'b0; bus.command_i = DFI_NOP; bus.bank_i = '0; bus.addr_i = '0;
      bus.rready_i = 1'b1; bus.wvalid_i = 1'b0; bus.wrlast_i = 1'b0; bus.wrmask_i = '0; bus.wrdata_i = '0;
      repeat (3) step();

      chk("rst_cke", dfi_cke_o, 0);
      chk("rst_dram_reset_n", dfi_reset_n_o, 0);
      chk("rst_cmd", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, 4'hF);
      chk("rst_strobes", {dfi_odt_o, dfi_wren_o, dfi_rden_o}, 0);
      chk("rst_bank_addr", {dfi_bank_o, dfi_addr_o}, 0);
      chk("rst_accept", bus.accept_o, 1);
      chk("rst_err", {wr_underrun_o, rd_overflow_o, wr_misalign_o}, 0);

      cke_i = 1'b1; ddr_rst_n_i = 1'b1; reset_n = 1'b1; mon_en = 1'b1;
      step();
      chk("cke_follow", dfi_cke_o, 1);
      chk("dram_reset_follow", dfi_reset_n_o, 1);
      chk("idle_nop", {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o}, 4'b0111);

      issue(CMD_WR, 3'd2, 15'h1234, 32'hA5A5A5A5, 20, a1, w);
      chk("wr1_wait", w, 0);
      repeat (12) step();
      chk("wr1_underrun", wr_underrun_o, 0);
      chk("wr1_misalign", wr_misalign_o, 0);

      issue(CMD_WR, 3'd1, 15'h0010, 32'h0F0F0F0F, 20, a1, w);
      issue(CMD_WR, 3'd1, 15'h0018, 32'h3C3C3C3C, 20, a2, w);
      chk("b2b_wait", w, 1);
      chk("b2b_gap", a2 - a1, BL);
      repeat (12) step();

      issue(CMD_WR, 3'd4, 15'h0100, 32'h12345678, 20, a1, w);
      issue(CMD_ACT, 3'd5, 15'h7FFF, '0, 20, a3, w);
      chk("act_not_blocked", w, 0);
      issue(CMD_RD, 3'd4, 15'h0140, '0, 30, a2, w);
      chk("wtr_gap", a2 - a1, 12);
      issue(CMD_WR, 3'd4, 15'h0180, 32'hDEADBEEF, 20, a3, w);
      chk("rtw_gap", a3 - a2, 2);
      repeat (15) step();
      chk("wr_underrun_clean", wr_underrun_o, 0);
      chk("wr_misalign_clean", wr_misalign_o, 0);

      for (int i = 0; i < 4; i++) begin
         rd = 32'hC0DE0000 + i;
         dfi_valid_i = 1'b1; dfi_data_i = rd;
         rexp_q.push_back({1'(i % BL == BL - 1), rd});
         step();
      end
      dfi_valid_i = 1'b0;
      step();
      chk("rd_no_overflow", rd_overflow_o, 0);
      rd = 32'hFEEDF00D;
      bus.rready_i = 1'b0; dfi_valid_i = 1'b1; dfi_data_i = rd;
      rexp_q.push_back({1'b0, rd});
      step();
      dfi_valid_i = 1'b0; bus.rready_i = 1'b1;
      step();
      chk("rd_overflow_set", rd_overflow_o, 1);
      repeat (3) step();
      chk("rd_overflow_sticky", rd_overflow_o, 1);

      issue(CMD_WR, 3'd3, 15'h0200, 32'h55AA55AA, 20, a1, w);
      drop_cyc = a1 + 1 + WL;
      issue(CMD_WR, 3'd3, 15'h0208, 32'h66996699, 20, a2, w);
      while (cyc < a1 + 1 + WL + 1) step();
      chk("underrun_set", wr_underrun_o, 1);
      step();
      reset_n = 1'b0;
      for (int i = cyc; i < N; i++) begin
         exp_wren[i] = 1'b0; exp_odt[i] = 1'b0; exp_rden[i] = 1'b0; exp_wlast[i] = 1'b0;
      end
      send_q.delete();
      wexp_q.delete();
      #1;
      chk("rst_mid_wren", dfi_wren_o, 0);
      chk("rst_mid_odt", dfi_odt_o, 0);
      chk("rst_mid_err", {wr_underrun_o, rd_overflow_o, wr_misalign_o}, 0);
      repeat (2) step();
      reset_n = 1'b1;
      repeat (4) step();
      chk("wq_drained", wexp_q.size(), 0);
      chk("rq_drained", rexp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr3_dfi_sched.md
# ddr3_dfi_sched

Parametrised DDR3 DFI command/data scheduler: registers controller commands onto the DFI command bus and generates correctly timed write-enable, read-enable and ODT strobes from the command stream. It enforces column-to-column (tCCD), write-to-read and read-to-write turnaround spacing by back-pressuring the controller. It sits between the DDR3 memory controller / AXI4 data FIFOs and the DDR3 PHY, and succeeds the fixed-timing DFI shim.

## Interface
- DDR_WR_LATENCY, 6: DFI command cycle to first write-data cycle (cycles, ≥2).
- DDR_RD_LATENCY, 5: DFI command cycle to first rden cycle (cycles, ≥1).
- BURST_CYCLES, 2: DFI data cycles per burst (≥1).
- TWTR_CYCLES, 4: extra gap after write data before a RD is accepted.
- DDR_DATA_WIDTH, 32; DDR_DQM_WIDTH, DDR_DATA_WIDTH/8; DDR_ROW_BITS, 15; DDR_BANK_BITS, 3 (fixed).
- clock  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cke_i / ddr_rst_n_i  in  1 / 1  requested CKE and DRAM RESET# levels.
- enable_i  in  1  command valid; command_i  in  4  {cs_n,ras_n,cas_n,we_n}.
- accept_o  out  1  command taken when enable_i & accept_o.
- bank_i  in  3; addr_i  in  DDR_ROW_BITS.
- wvalid_i in 1; wready_o out 1; wrlast_i in 1; wrmask_i in DQM; wrdata_i in DATA.
- rvalid_o out 1; rready_i in 1; rdlast_o out 1; rddata_o out DATA.
- dfi_cke_o, dfi_reset_n_o, dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o, dfi_odt_o  out  1 each.
- dfi_bank_o out 3; dfi_addr_o out DDR_ROW_BITS.
- dfi_wren_o out 1; dfi_mask_o out DQM; dfi_data_o out DATA.
- dfi_rden_o out 1; dfi_valid_i in 1; dfi_data_i in DATA.
- wr_underrun_o, rd_overflow_o, wr_misalign_o  out  1 each, sticky error flags.

## Operation
- Encodings: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000, ZQCL 0110; cs_n=1 is deselect.
- Accepted command is registered onto dfi_cs/ras/cas/we/bank/addr next cycle (cycle C). Otherwise outputs NOP (0111), bank/addr hold.
- dfi_cke_o, dfi_reset_n_o: registered copies of cke_i, ddr_rst_n_i.
- Counters (all decrement to 0, saturate):
  - ccd: loaded BURST_CYCLES-1 on any accepted RD/WR; any CAS blocked while ≠0.
  - wtr: loaded DDR_WR_LATENCY+BURST_CYCLES+TWTR_CYCLES-1 on WR; RD blocked while ≠0.
  - rtw: loaded max(0, DDR_RD_LATENCY+BURST_CYCLES+1-DDR_WR_LATENCY)-1 on RD; WR blocked while ≠0.
- accept_o combinational from command_i and counters; non-CAS commands are never blocked.
- Write window: dfi_wren_o high cycles C+WL .. C+WL+BURST_CYCLES-1; dfi_odt_o high C+WL-1 .. C+WL+BURST_CYCLES.
- wready_o = dfi_wren_o; dfi_data_o/dfi_mask_o = wrdata_i/wrmask_i (pass-through).
- wr_underrun_o set if dfi_wren_o & !wvalid_i; wr_misalign_o set if wrlast_i disagrees with last window cycle.
- Read window: dfi_rden_o high C+RL .. C+RL+BURST_CYCLES-1.
- rvalid_o = dfi_valid_i, rddata_o = dfi_data_i; beat counter 0..BURST_CYCLES-1 wraps; rdlast_o = rvalid_o & (beat==BURST_CYCLES-1).
- rd_overflow_o set if rvalid_o & !rready_i (no read back-pressure exists).

## Timing
- Reset values: cke 0, dfi_reset_n 0, cs/ras/cas/we 1, odt/wren/rden 0, bank/addr 0, counters 0, beat 0, error flags 0; accept_o therefore 1 in reset (controller must not issue).
- Command latency: 1 cycle. Back-to-back WR→WR: next WR accepted BURST_CYCLES cycles later; windows abut with no wren gap.
- Defaults: WR→RD min spacing 12 cycles; RD→WR min spacing 2 cycles.
- Reset assertion mid-burst clears all pending windows immediately and asynchronously.
- Window shift registers width WL+BURST_CYCLES+1; counters $clog2(max load+1) bits.
- Overlapping rden/wren windows are impossible by construction; assertion required.

## Structure
- Shared defines/package: command encodings, DDR_BANK_BITS, DFI NOP/deselect constants.
- Sub-module ddr3_dfi_window: parametrised delay-line strobe generator (DELAY, LENGTH, PRE, POST); instantiated for wren, odt, rden.

## Test plan
- Reset release, NOP idle -> outputs at reset values, dfi_cke_o follows cke_i=1 next cycle.
- WR at C (defaults) -> dfi_wren_o cycles C+6,C+7; dfi_odt_o C+5..C+8; wrdata 0xA5A5A5A5 on dfi_data_o.
- Two WRs back-to-back -> second accept_o low 1 cycle; wren high 4 contiguous cycles.
- WR then RD presented immediately -> RD accepted 12 cycles after WR; rden at its C+5,C+6.
- RD returns 4 beats with rready_i=1 -> rdlast_o on beats 2 and 4; rready_i=0 on a beat -> rd_overflow_o sticky 1.
- reset_n low during write window -> wren/odt drop at once; wvalid_i low inside window -> wr_underrun_o set.
